// File: rtl/approx_div_pkg.sv
// rtl/approx_div_pkg.sv - shared types, defaults and cell-select mask helper for the approximate divider
package approx_div_pkg;

  localparam int DW_DEFAULT         = 8;
  localparam int APPROX_MAX_DEFAULT = 7;
  // Width of the mask helper's return value; callers slice off their DW low bits (DW <= MASK_W-1).
  localparam int MASK_W             = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit i set when cell i of this row is an approximate cell: the row uses min(row, amax) of them.
  function automatic logic [MASK_W-1:0] approx_mask(input int row, input logic en, input int amax);
    logic [MASK_W-1:0] m;
    int lim;
    lim = (row < amax) ? row : amax;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = en & (i < lim);
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_div_row.sv
// rtl/approx_div_row.sv - one restoring subtractor row built from exact and approximate borrow cells
module approx_div_row #(
  parameter int DW = 8
) (
  input  logic [DW:0]   x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] mask,
  output logic          qs,
  output logic [DW-1:0] rout
);

  // b[i] is the borrow into cell i; b[DW] is the borrow out of the MSB cell
  logic [DW:0] b;

  // Ripple the borrow chain, each cell exact or approximate according to mask
  always_comb begin
    b    = '0;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (mask[i]) begin
        b[i+1] = b[i] & (y[i] | ~x[i]);
      end else begin
        b[i+1] = (~x[i] & b[i]) | (~x[i] & y[i]) | (y[i] & b[i]);
      end
    end
  end

  // A set x[DW] means the partial remainder already exceeds any DW-bit divisor
  assign qs = ~b[DW] | x[DW];

  // Restore (keep x) or take the difference bit, per cell type
  always_comb begin
    rout = '0;
    for (int i = 0; i < DW; i++) begin
      if (mask[i]) begin
        rout[i] = x[i] | (qs & (y[i] ^ b[i]));
      end else begin
        rout[i] = qs ? (x[i] ^ y[i] ^ b[i]) : x[i];
      end
    end
  end

endmodule

// File: rtl/approx_seq_divider.sv
// rtl/approx_seq_divider.sv - sequential approximate restoring divider; APPROX_DIV_ERR_MON_EN adds an exact shadow row and error outputs
module approx_seq_divider
  import approx_div_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int APPROX_MAX = APPROX_MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  input  logic            approx_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            dbz,
  output logic            ovf
`ifdef APPROX_DIV_ERR_MON_EN
  ,
  output logic [DW-1:0]   exact_quotient,
  output logic [DW-1:0]   exact_remainder,
  output logic [DW-1:0]   q_err
`endif
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_ROW = CW'(DW - 1);

  state_t state_q, state_d;

  logic [DW:0]   x_q;      // partial remainder fed to the row
  logic [DW-1:0] lo_q;     // dividend bits still to be shifted in, MSB first
  logic [DW-1:0] y_q;
  logic [CW-1:0] row_q;
  logic          approx_q;
  logic [DW-1:0] quot_q;
  logic [DW-1:0] rem_q;
  logic          dbz_q;
  logic          ovf_q;

  logic [MASK_W-1:0] mask_full;
  logic [DW-1:0]     mask;
  logic              unused_mask_hi;
  logic              qs;
  logic [DW-1:0]     rout;

  assign mask_full      = approx_mask(int'(row_q), approx_q, APPROX_MAX);
  assign mask           = mask_full[DW-1:0];
  assign unused_mask_hi = ^mask_full[MASK_W-1:DW];

  approx_div_row #(.DW(DW)) u_row (
    .x    (x_q),
    .y    (y_q),
    .mask (mask),
    .qs   (qs),
    .rout (rout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: divide-by-zero skips RUN, last row finishes, handshake frees DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : RUN;
      RUN:  if (row_q == LAST_ROW) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state_q == IDLE) & ~rst;
    out_valid = (state_q == DONE);
  end

  // Operand capture and one quotient bit per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      lo_q     <= '0;
      y_q      <= '0;
      row_q    <= '0;
      approx_q <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q      <= dividend[2*DW-1:DW-1];
            lo_q     <= {dividend[DW-2:0], 1'b0};
            y_q      <= divisor;
            row_q    <= '0;
            approx_q <= approx_en;
            ovf_q    <= (dividend[2*DW-1:DW] >= divisor);
            dbz_q    <= (divisor == '0);
            if (divisor == '0) begin
              quot_q <= '1;
              rem_q  <= dividend[DW-1:0];
            end
          end
        end
        RUN: begin
          quot_q <= {quot_q[DW-2:0], qs};
          if (row_q != LAST_ROW) begin
            x_q   <= {rout, lo_q[DW-1]};
            lo_q  <= {lo_q[DW-2:0], 1'b0};
            row_q <= row_q + 1'b1;
          end else begin
            rem_q <= rout;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

`ifdef APPROX_DIV_ERR_MON_EN
  logic [DW:0]   xe_q;
  logic [DW-1:0] eq_q;
  logic [DW-1:0] er_q;
  logic          qs_e;
  logic [DW-1:0] rout_e;

  approx_div_row #(.DW(DW)) u_row_exact (
    .x    (xe_q),
    .y    (y_q),
    .mask ({DW{1'b0}}),
    .qs   (qs_e),
    .rout (rout_e)
  );

  // Shadow exact division stepped in lock-step with the main row
  always_ff @(posedge clk) begin
    if (rst) begin
      xe_q <= '0;
      eq_q <= '0;
      er_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            xe_q <= dividend[2*DW-1:DW-1];
            if (divisor == '0) begin
              eq_q <= '1;
              er_q <= dividend[DW-1:0];
            end
          end
        end
        RUN: begin
          eq_q <= {eq_q[DW-2:0], qs_e};
          if (row_q != LAST_ROW) begin
            xe_q <= {rout_e, lo_q[DW-1]};
          end else begin
            er_q <= rout_e;
          end
        end
        default: ;
      endcase
    end
  end

  assign exact_quotient  = eq_q;
  assign exact_remainder = er_q;
  assign q_err           = (quot_q >= eq_q) ? (quot_q - eq_q) : (eq_q - quot_q);
`endif

endmodule
